mod_n_updown_counter: RTL and testbench
=======================================

// Module: mod_n_updown_counter
// PURPOSE
//  Parametrised up/down modulo-N counter; successor to the fixed mod-12 counter.
//  Adds the following over the fixed block:
//   - count enable, saturate-or-wrap mode and a range-checked parallel load
//   - terminal-count and wrap flags, plus a saturating count of wrap events
//  Used as a timebase/sequencer primitive; tc/wrap allow cascading counters.
// PARAMETERS
//  MODULUS    12                  count range 0..MODULUS-1; legal range MODULUS >= 2
//  CNT_W      $clog2(MODULUS)     width of dataout/datain (derived, do not override)
//  WRAP_CNT_W 8                   width of wrap event counter, legal range >= 1
// PORTS
//  clk       in   1           sole clock, rising edge
//  rst       in   1           asynchronous, active-low reset (0 = reset)
//  en        in   1           count enable
//  mode      in   1           1 = up, 0 = down
//  sat       in   1           1 = saturate at range ends, 0 = wrap
//  load      in   1           parallel load request
//  datain    in   CNT_W       load value
//  clr_wraps in   1           synchronous clear of wrap_cnt
//  dataout   out  CNT_W       current count, registered
//  tc        out  1           terminal count: (mode & dataout==MODULUS-1) | (~mode & dataout==0)
//  wrap      out  1           registered 1-cycle pulse, high in the cycle the wrapped value is shown
//  load_err  out  1           registered 1-cycle pulse: load with datain >= MODULUS
//  wrap_cnt  out  WRAP_CNT_W  wrap events since reset/clear, saturates at all-ones
// BEHAVIOUR
//  Reset (rst=0, async assert, sync deassert at the block's input):
//   dataout=0, wrap=0, load_err=0, wrap_cnt=0. tc is then the function of mode.
//  Per rising edge, priority load > count:
//   - load & datain<MODULUS: dataout<=datain; no wrap; en ignored this cycle.
//   - load & datain>=MODULUS: load_err<=1; load dropped; falls through to count rule.
//   - en & mode, dataout<MODULUS-1: dataout+1.
//   - en & mode, dataout==MODULUS-1: sat ? hold : (0, wrap<=1).
//   - en & ~mode, dataout>0: dataout-1.
//   - en & ~mode, dataout==0: sat ? hold : (MODULUS-1, wrap<=1).
//   - ~en, no valid load: hold.
//  wrap and load_err are 0 in every cycle other than the one they pulse.
//  No wrap pulse when saturating and holding at a range end.
//  tc is combinational from dataout and mode only; it does not depend on en.
//  wrap_cnt: increments on each cycle with wrap<=1.
//   - clr_wraps has priority: clear wins over a simultaneous wrap (result 0).
//   - Holds at 2^WRAP_CNT_W-1; no rollover.
//  mode/sat may change on any cycle; the new values take effect on that edge.
//  Width: next-value arithmetic in CNT_W+1 bits; dataout never leaves 0..MODULUS-1.
//   This holds when MODULUS is not a power of two.
//  Reset asserted mid-count: all regs clear immediately, independent of clk.
// STRUCTURE
//  counter_pkg holds the following:
//   - typedef enum logic {DIR_DOWN=0, DIR_UP=1} dir_e
//   - function next_count(cur, dir, sat, MODULUS) returning {wrapped, next}
//  One sub-module, sat_event_counter:
//   - parameter W; ports clk, rst, inc, clr, cnt
//   - instanced for wrap_cnt
//   - reusable for other event statistics
//  Top-level holds the dataout/wrap/load_err registers and load validation.
// TESTING (MODULUS=12, WRAP_CNT_W=2 unless noted)
//  1 rst=0 mid-count at dataout=7 -> all outputs 0 asynchronously;
//    after release with en=1, mode=1 -> 1,2,3 on successive edges.
//  2 en=1, mode=1, sat=0 from 10 -> 11 (tc=1), 0 (wrap=1 one cycle), 1;
//    down from 1 -> 0 (tc=1), 11 (wrap=1).
//  3 sat=1, up at 11 -> stays 11, wrap=0; down at 0 -> stays 0, wrap=0.
//  4 load=1, datain=5 with en=1 -> 5, no increment;
//    datain=13 with en=1, dataout=3 -> load_err=1, dataout=4.
//  5 Force 5 wraps -> wrap_cnt 1,2,3,3,3;
//    clr_wraps coincident with a wrap -> 0.
//  6 MODULUS=5 (CNT_W=3): up from 4 -> 0; load datain=5, 6 or 7 -> load_err;
//    dataout never exceeds 4.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and next-state arithmetic for the modulo-N up/down counter family.
// Widths are fixed at CNT_MAX_W so the helper can serve any counter instance.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Wide enough for any practical modulus and leaves headroom above CNT_W,
  // so cur+1 at the top of range cannot alias back into 0..MODULUS-1.
  localparam int unsigned CNT_MAX_W = 32;

  typedef struct packed {
    logic                 wrapped;
    logic [CNT_MAX_W-1:0] value;
  } next_t;

  // Next count for one enabled step; holds at a range end when sat is set,
  // otherwise wraps to the opposite end and flags it.
  function automatic next_t next_count(
    input logic [CNT_MAX_W-1:0] cur,
    input dir_e                 dir,
    input logic                 sat,
    input int unsigned          modulus
  );
    next_t res;
    // NOTE: every field gets a default before the branches, so no path leaves
    // it unassigned; in an always_comb the same habit is what prevents latches.
    res.wrapped = 1'b0;
    res.value   = cur;
    if (dir == DIR_UP) begin
      if (cur < (modulus - 1)) begin
        res.value = cur + 1;
      end else if (!sat) begin
        res.value   = '0;
        res.wrapped = 1'b1;
      end
    end else begin
      if (cur != '0) begin
        res.value = cur - 1;
      end else if (!sat) begin
        res.value   = modulus - 1;
        res.wrapped = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones,
// synchronous clear wins over a coincident increment.
module sat_event_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/mod_n_updown_counter.sv
// Parametrised up/down modulo-N counter with enable, saturate/wrap mode,
// range-checked parallel load, terminal-count/wrap flags and a wrap statistic.
module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned MODULUS    = 12,
  parameter int unsigned CNT_W      = $clog2(MODULUS),
  parameter int unsigned WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sat,
  input  logic                  load,
  input  logic [CNT_W-1:0]      datain,
  input  logic                  clr_wraps,
  output logic [CNT_W-1:0]      dataout,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
);

  localparam logic [CNT_W-1:0] TOP_VAL = CNT_W'(MODULUS - 1);
  localparam logic [CNT_W:0]   MOD_VAL = (CNT_W + 1)'(MODULUS);

  logic [CNT_W-1:0] r_dataout;
  logic             r_wrap;
  logic             r_load_err;

  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_wrap_nxt;
  next_t            w_next;
  logic             w_unused_hi;

  // Out-of-range load values are rejected; the cycle then counts as if no
  // load had been requested.
  assign w_load_ok  = load && ({1'b0, datain} < MOD_VAL);
  assign w_load_bad = load && !w_load_ok;

  assign w_next      = next_count(CNT_MAX_W'(r_dataout), dir_e'(mode), sat, MODULUS);
  assign w_unused_hi = ^w_next.value[CNT_MAX_W-1:CNT_W];

  assign w_wrap_nxt = !w_load_ok && en && w_next.wrapped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dataout  <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_load_bad;
      if (w_load_ok) begin
        r_dataout <= datain;
      end else if (en) begin
        r_dataout <= w_next.value[CNT_W-1:0];
      end
    end
  end

  // Counts on the same edge that raises wrap, so wrap_cnt and wrap agree.
  sat_event_counter #(
    .W (WRAP_CNT_W)
  ) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_wrap_nxt),
    .clr (clr_wraps),
    .cnt (wrap_cnt)
  );

  assign dataout  = r_dataout;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;
  assign tc       = (mode && (r_dataout == TOP_VAL)) || (!mode && (r_dataout == '0));

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed self-checking bench: a MODULUS=12/WRAP_CNT_W=2 instance and a
// MODULUS=5 instance, expected values hand-computed per vector.
module tb_mod_n_updown_counter;

  logic clk;
  logic rst;

  // Instance A: MODULUS=12, CNT_W=4, WRAP_CNT_W=2
  logic       a_en, a_mode, a_sat, a_load, a_clr;
  logic [3:0] a_datain;
  logic [3:0] a_dataout;
  logic       a_tc, a_wrap, a_load_err;
  logic [1:0] a_wrap_cnt;

  // Instance B: MODULUS=5, CNT_W=3, WRAP_CNT_W=8
  logic       b_en, b_mode, b_sat, b_load, b_clr;
  logic [2:0] b_datain;
  logic [2:0] b_dataout;
  logic       b_tc, b_wrap, b_load_err;
  logic [7:0] b_wrap_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mod_n_updown_counter #(.MODULUS(12), .WRAP_CNT_W(2)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .en        (a_en),
    .mode      (a_mode),
    .sat       (a_sat),
    .load      (a_load),
    .datain    (a_datain),
    .clr_wraps (a_clr),
    .dataout   (a_dataout),
    .tc        (a_tc),
    .wrap      (a_wrap),
    .load_err  (a_load_err),
    .wrap_cnt  (a_wrap_cnt)
  );

  mod_n_updown_counter #(.MODULUS(5)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .en        (b_en),
    .mode      (b_mode),
    .sat       (b_sat),
    .load      (b_load),
    .datain    (b_datain),
    .clr_wraps (b_clr),
    .dataout   (b_dataout),
    .tc        (b_tc),
    .wrap      (b_wrap),
    .load_err  (b_load_err),
    .wrap_cnt  (b_wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int cnt, input bit t, input bit w);
    check({tag, " dataout"}, 32'(a_dataout), cnt);
    check({tag, " tc"},      32'(a_tc),      32'(t));
    check({tag, " wrap"},    32'(a_wrap),    32'(w));
  endtask

  int exp_b;

  initial begin
    rst = 1'b0;
    {a_en, a_mode, a_sat, a_load, a_clr} = '0;
    {b_en, b_mode, b_sat, b_load, b_clr} = '0;
    a_datain = '0;
    b_datain = '0;

    // Reset state: mode=0 so tc reflects dataout==0
    step();
    check_a("reset", 0, 1'b1, 1'b0);
    check("reset load_err", 32'(a_load_err), 0);
    check("reset wrap_cnt", 32'(a_wrap_cnt), 0);
    rst = 1'b1;

    // 1: async reset mid-count at 7, then count 1,2,3
    a_load = 1'b1; a_datain = 4'd7; a_mode = 1'b1;
    step();
    check("t1 load7", 32'(a_dataout), 7);
    a_load = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_a("t1 async rst", 0, 1'b0, 1'b0);
    check("t1 async rst load_err", 32'(a_load_err), 0);
    check("t1 async rst wrap_cnt", 32'(a_wrap_cnt), 0);
    step();
    rst = 1'b1;
    a_en = 1'b1;
    step(); check("t1 cnt1", 32'(a_dataout), 1);
    step(); check("t1 cnt2", 32'(a_dataout), 2);
    step(); check("t1 cnt3", 32'(a_dataout), 3);

    // 2: wrap up from 11, wrap down from 0
    a_load = 1'b1; a_datain = 4'd10;
    step(); check_a("t2 load10", 10, 1'b0, 1'b0);
    a_load = 1'b0;
    step(); check_a("t2 up11", 11, 1'b1, 1'b0);
    step(); check_a("t2 up wrap0", 0, 1'b0, 1'b1);
    check("t2 wrap_cnt1", 32'(a_wrap_cnt), 1);
    step(); check_a("t2 up1", 1, 1'b0, 1'b0);
    a_mode = 1'b0;
    step(); check_a("t2 dn0", 0, 1'b1, 1'b0);
    step(); check_a("t2 dn wrap11", 11, 1'b0, 1'b1);
    check("t2 wrap_cnt2", 32'(a_wrap_cnt), 2);

    // 3: saturate at both ends
    a_sat = 1'b1; a_mode = 1'b1;
    step(); check_a("t3 sat hold11", 11, 1'b1, 1'b0);
    step(); check_a("t3 sat hold11b", 11, 1'b1, 1'b0);
    a_mode = 1'b0; a_load = 1'b1; a_datain = 4'd0;
    step(); a_load = 1'b0;
    step(); check_a("t3 sat hold0", 0, 1'b1, 1'b0);
    check("t3 wrap_cnt", 32'(a_wrap_cnt), 2);

    // 4: valid load beats enable; invalid load falls through to count
    a_sat = 1'b0; a_mode = 1'b1; a_load = 1'b1; a_datain = 4'd5;
    step(); check_a("t4 load5", 5, 1'b0, 1'b0);
    check("t4 load5 load_err", 32'(a_load_err), 0);
    a_datain = 4'd3;
    step(); check("t4 load3", 32'(a_dataout), 3);
    a_datain = 4'd13;
    step(); check("t4 bad load dataout", 32'(a_dataout), 4);
    check("t4 bad load load_err", 32'(a_load_err), 1);
    a_load = 1'b0;
    step(); check("t4 after dataout", 32'(a_dataout), 5);
    check("t4 after load_err", 32'(a_load_err), 0);

    // 5: wrap_cnt saturation and clear priority
    a_clr = 1'b1;
    step(); check("t5 clr", 32'(a_wrap_cnt), 0);
    a_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_load = 1'b1; a_datain = 4'd11;
      step();
      a_load = 1'b0;
      step();
      check_a($sformatf("t5 wrap%0d", i), 0, 1'b0, 1'b1);
      check($sformatf("t5 wrap_cnt%0d", i), 32'(a_wrap_cnt), (i < 2) ? i + 1 : 3);
    end
    a_load = 1'b1; a_datain = 4'd11;
    step();
    a_load = 1'b0; a_clr = 1'b1;
    step();
    check("t5 clr+wrap wrap", 32'(a_wrap), 1);
    check("t5 clr+wrap wrap_cnt", 32'(a_wrap_cnt), 0);
    a_clr = 1'b0;

    // 6: MODULUS=5 wraps at 4, rejects loads 5..7, never exceeds 4
    b_en = 1'b1; b_mode = 1'b1; b_load = 1'b1; b_datain = 3'd4;
    step(); check("t6 load4", 32'(b_dataout), 4);
    check("t6 tc4", 32'(b_tc), 1);
    b_load = 1'b0;
    step(); check("t6 wrap0", 32'(b_dataout), 0);
    check("t6 wrap", 32'(b_wrap), 1);
    b_load = 1'b1;
    for (int v = 5; v <= 7; v++) begin
      b_datain = 3'(v);
      step();
      check($sformatf("t6 bad%0d load_err", v), 32'(b_load_err), 1);
      check($sformatf("t6 bad%0d dataout", v), 32'(b_dataout), v - 4);
    end
    b_load = 1'b0;
    exp_b = 3;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_b = (exp_b + 1) % 5;
      check($sformatf("t6 run%0d", i), 32'(b_dataout), exp_b);
      check($sformatf("t6 run%0d range", i), 32'(b_dataout <= 3'd4), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
